// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the time-multiplexed adder controller.
package adder_share_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder_share_ctrl_rr_pick.sv
// Combinational round-robin selector: first set request after the last winner.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            any,
    output logic [IDW-1:0]  win_id,
    output logic [NREQ-1:0] win_onehot
);

    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        any    = |req;
        win_id = '0;
        found  = 1'b0;
        idx    = last;
        // Walk last+1, last+2, ... with an explicit wrap so non-power-of-two NREQ works.
        for (int k = 0; k < NREQ; k++) begin
            idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_onehot[i] = any && (win_id == IDW'(i));
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Arbitrates NREQ requesters onto one registered adder and returns the sum on a
// valid/ready channel. Response: rsp_valid holds with stable id/sum until rsp_valid && rsp_ready.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    output logic                  busy
);

    state_e             state_q;
    logic [IDW-1:0]     last_q;
    logic [IDW-1:0]     id_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [NREQ-1:0]    gnt_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [WIDTH:0]     rsp_sum_q;
    logic               busy_q;

    logic               any;
    logic [IDW-1:0]     win_id;
    logic [NREQ-1:0]    win_onehot;

    logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
    logic [WIDTH-1:0]           sel_a, sel_b;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req        (req),
        .last       (last_q),
        .any        (any),
        .win_id     (win_id),
        .win_onehot (win_onehot)
    );

    assign a_arr = op_a;
    assign b_arr = op_b;
    assign sel_a = a_arr[win_id];
    assign sel_b = b_arr[win_id];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Operands are captured here, so later changes by the requester are harmless.
                    if (any) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        id_q    <= win_id;
                        last_q  <= win_id;
                        gnt_q   <= win_onehot;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    rsp_sum_q   <= {1'b0, a_q} + {1'b0, b_q};
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    gnt_q       <= '0;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    gnt_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed and randomized checks of adder_share_ctrl against a round-robin reference model.
module tb_adder_share_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = $clog2(NREQ);
    localparam int EW    = IDW + WIDTH + 1;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a, op_b;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;
    logic                  busy;

    adder_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // reference model state
    int               n_cmp = 0;
    int               n_err = 0;
    int               last_m;
    int               a_m[NREQ];
    int               b_m[NREQ];
    logic [EW-1:0]    exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (((r >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic apply_ops();
        for (int i = NREQ - 1; i >= 0; i--) begin
            op_a[WIDTH*NREQ-1:0] = {op_a[WIDTH*NREQ-WIDTH-1:0], WIDTH'(a_m[i])};
            op_b[WIDTH*NREQ-1:0] = {op_b[WIDTH*NREQ-WIDTH-1:0], WIDTH'(b_m[i])};
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_gnt",   32'(gnt), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id",    32'(rsp_id), 32'd0);
        chk("rst_sum",   32'(rsp_sum), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        last_m = NREQ - 1;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    // One complete transaction: grant, response, optional stall, handshake.
    task automatic do_txn(input logic [NREQ-1:0] r, input bit drop, input int stall,
                          input bit mutate);
        int            waits;
        int            w;
        logic [EW-1:0] e;
        logic [NREQ-1:0] oh;
        req       = r;
        rsp_ready = (stall == 0);
        waits     = 0;
        do begin
            @(posedge clk); #1;
            waits++;
        end while (gnt == '0 && waits < 8);
        w  = model_pick(r, last_m);
        oh = NREQ'(1) << w;
        chk("grant_latency", 32'(waits), 32'd1);
        chk("gnt",           32'(gnt), 32'(oh));
        chk("busy_add",      32'(busy), 32'd1);
        exp_q.push_back({IDW'(w), (WIDTH+1)'(a_m[w] + b_m[w])});
        last_m = w;
        if (drop) req = r & ~oh;
        if (mutate) begin
            a_m[w] = (a_m[w] + 5) % (1 << WIDTH);
            apply_ops();
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id",    32'(rsp_id), 32'(e[EW-1 -: IDW]));
        chk("rsp_sum",   32'(rsp_sum), 32'(e[WIDTH:0]));
        chk("gnt_drop",  32'(gnt), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_id",    32'(rsp_id), 32'(e[EW-1 -: IDW]));
            chk("stall_sum",   32'(rsp_sum), 32'(e[WIDTH:0]));
            chk("stall_gnt",   32'(gnt), 32'd0);
            chk("stall_busy",  32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid",    32'(rsp_valid), 32'd0);
        chk("hs_busy",     32'(busy), 32'd0);
        chk("hs_sum_hold", 32'(rsp_sum), 32'(e[WIDTH:0]));
    endtask

    initial begin
        reset = 1'b1; req = '0; rsp_ready = 1'b0; op_a = '0; op_b = '0;
        for (int i = 0; i < NREQ; i++) begin a_m[i] = 0; b_m[i] = 0; end
        do_reset();

        // single request
        a_m[0] = 3; b_m[0] = 5; apply_ops();
        do_txn(4'b0001, 1'b1, 0, 1'b0);

        // carry into the extra bit
        a_m[2] = 15; b_m[2] = 15; apply_ops();
        do_txn(4'b0100, 1'b1, 0, 1'b0);

        // round robin with all requesters held
        do_reset();
        for (int i = 0; i < NREQ; i++) begin a_m[i] = i + 1; b_m[i] = 2 * i + 7; end
        apply_ops();
        for (int t = 0; t < 5; t++) do_txn(4'b1111, 1'b0, 0, 1'b0);

        // single requester re-granted
        for (int t = 0; t < 3; t++) do_txn(4'b0100, 1'b0, 0, 1'b0);

        // backpressure with other requests pending, then follow-on grant
        do_txn(4'b1111, 1'b0, 5, 1'b0);
        do_txn(4'b1111, 1'b0, 0, 1'b0);

        // operand change after grant
        a_m[1] = 4; b_m[1] = 4; apply_ops();
        do_txn(4'b0010, 1'b1, 0, 1'b1);

        // reset while a response is pending
        req = 4'b0010; rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_gnt",   32'(gnt), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        req = '0;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        do_txn(4'b1000, 1'b1, 0, 1'b0);
        do_reset();
        do_txn(4'b1001, 1'b0, 0, 1'b0);
        do_txn(4'b1001, 1'b1, 0, 1'b0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_m[i] = int'($urandom_range(0, (1 << WIDTH) - 1));
                b_m[i] = int'($urandom_range(0, (1 << WIDTH) - 1));
            end
            apply_ops();
            do_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Shares one registered WIDTH-bit adder among NREQ requesters.
- Arbitrates round-robin, captures the winner's operands, sequences the add, and returns the sum with requester ID over a valid/ready response channel.
- Sits between the ui_in-side requester logic and the single adder datapath, so that datapath is time-multiplexed rather than replicated.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits.
- IDW, $clog2(NREQ), requester ID width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until granted.
- op_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- op_b  input  NREQ*WIDTH  operand B; same packing as op_a.
- gnt  output  NREQ  one-hot, one-cycle grant pulse, registered.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  ID of the requester the response belongs to.
- rsp_sum  output  WIDTH+1  op_a + op_b, zero-extended, with the carry in the MSB.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync to clk on release):
  - state=IDLE; gnt=0; rsp_valid=0; rsp_id=0; rsp_sum=0; busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Any in-flight transaction is discarded; no response is ever produced for it.
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the clock edge:
    - Select the winner w: the first set req bit searching last+1, last+2, ... modulo NREQ.
    - Latch op_a[w] and op_b[w] into operand registers and w into id_q.
    - Set last=w, gnt=onehot(w), and go to ADD.
- ADD (exactly 1 cycle):
  - gnt is high for this cycle only. The requester must drop req, or present a new request, after seeing gnt.
  - req is ignored in every state except IDLE.
  - At the edge: rsp_sum <= a_q + b_q at WIDTH+1 bits; rsp_id <= id_q; rsp_valid <= 1; gnt <= 0; go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_sum stay stable until the rsp_valid && rsp_ready edge.
  - On that edge: rsp_valid <= 0, go to IDLE.
  - rsp_sum and rsp_id hold their last value after the handshake; they are not cleared.
- Latency and throughput:
  - req high in IDLE at edge k -> gnt high during cycle k+1 -> rsp_valid high from edge k+2.
  - Minimum cycle per transaction is 3 clocks with rsp_ready tied high.
- Arithmetic:
  - Unsigned, no saturation.
  - Maximum case: (2^WIDTH-1)+(2^WIDTH-1) = 2^(WIDTH+1)-2, which fits in WIDTH+1 bits.
- Boundary conditions:
  - All requesters active: grants rotate 0,1,2,...,NREQ-1,0; no starvation.
  - Single requester held high: it is re-granted every transaction; the pointer does not skip it.
  - Operands change after grant: no effect on the result, because operands are captured at the grant edge.
  - rsp_ready held low: the FSM stalls in RESP indefinitely; no further grants are issued.
  - rsp_ready high while not in RESP: ignored.
  - reset asserted in any state: all outputs go to their reset values immediately (asynchronous).

Decomposition:
- Package adder_share_pkg holds:
  - The state enum: IDLE, ADD, RESP (2-bit encoding).
  - Default constants NREQ_DEF=4 and WIDTH_DEF=4.
- Sub-module rr_pick: purely combinational round-robin selector.
  - Inputs: req[NREQ], last[IDW].
  - Outputs: any, win_id[IDW], win_onehot[NREQ].
  - Instantiated once in adder_share_ctrl.
- The pointer register, FSM, operand/result registers and handshake all live in adder_share_ctrl.

Test Plan:
- Reset then single request: reset pulse; req=0001, a0=3, b0=5, rsp_ready=1 -> gnt=0001 one cycle later; rsp_valid with rsp_id=0, rsp_sum=8 two cycles after req.
- Carry and overflow width: req=0100, a2=15, b2=15 -> rsp_id=2, rsp_sum=5'b11110 (30).
- Round-robin fairness: req=1111 held, all operand pairs distinct, rsp_ready=1 -> grant order 0,1,2,3,0; rsp_sum matches each requester's pair; one response every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, other req bits high -> rsp_valid, rsp_id and rsp_sum stable; gnt stays 0; busy=1. Raise rsp_ready -> handshake completes, and the next grant follows 1 cycle after return to IDLE.
- Operand capture: a1=4, b1=4 granted, then a1 changed to 9 during ADD -> rsp_sum=8.
- Reset mid-operation: assert reset while in RESP with rsp_valid=1 -> rsp_valid=0, gnt=0, busy=0 immediately. After release, req=1000 -> requester 3 is granted, and with req=1001 requester 0 wins first (pointer reset).
